snn_pred_filter: RTL and testbench

Post-inference decision filter downstream of `snn_fc_top`. It samples the binary `predicted_class` on each rising edge of the SNN `done` flag and keeps a sliding window of the last WINDOW predictions. A hysteresis state machine turns the window into a stable straight/turning steering decision. Each decision change is issued as a command through a valid/ready handshake to the flight-control interface.

---
 rtl/snn_pred_filter.sv | 98 +++++++++
 tb/tb_snn_pred_filter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/snn_pred_filter.sv
// Sliding-window hysteresis filter over SNN class predictions.
// Each change of the steering decision is issued as a valid/ready command.
module snn_pred_filter #(
   parameter int WINDOW     = 8,
   parameter int ON_THRESH  = 6,
   parameter int OFF_THRESH = 2,
   parameter int CNT_W      = $clog2(WINDOW+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inf_done,
   input  logic             inf_class,
   input  logic             clear,
   output logic             cmd_valid,
   output logic             cmd_turn,
   input  logic             cmd_ready,
   output logic             turning,
   output logic [CNT_W-1:0] fill_count,
   output logic [CNT_W-1:0] turn_count,
   output logic             overrun
);

   typedef enum logic {ST_STRAIGHT = 1'b0, ST_TURNING = 1'b1} state_t;

   localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] ON_C  = CNT_W'(ON_THRESH);
   localparam logic [CNT_W-1:0] OFF_C = CNT_W'(OFF_THRESH);

   state_t            state, state_nxt;
   logic              done_q, upd_q, accept, full, load;
   logic [WINDOW-1:0] win;

   assign accept  = inf_done & ~done_q;
   assign full    = (fill_count == WIN_C);
   assign turning = (state == ST_TURNING);

   // Window and counts; the count tracks the bit leaving the window instead of a popcount.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q     <= 1'b0;
         upd_q      <= 1'b0;
         win        <= '0;
         fill_count <= '0;
         turn_count <= '0;
      end else begin
         done_q <= inf_done;
         if (clear) begin
            upd_q      <= 1'b0;
            win        <= '0;
            fill_count <= '0;
            turn_count <= '0;
         end else begin
            upd_q <= accept;
            if (accept) begin
               win <= {win[WINDOW-2:0], inf_class};
               if (!full) begin
                  fill_count <= fill_count + CNT_W'(1);
                  turn_count <= turn_count + CNT_W'(inf_class);
               end else begin
                  turn_count <= turn_count + CNT_W'(inf_class) - CNT_W'(win[WINDOW-1]);
               end
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (upd_q && full) begin
         case (state)
            ST_STRAIGHT: if (turn_count >= ON_C)  state_nxt = ST_TURNING;
            ST_TURNING:  if (turn_count <= OFF_C) state_nxt = ST_STRAIGHT;
            default:     state_nxt = ST_STRAIGHT;
         endcase
      end
      load = (state_nxt != state);
   end

   // A newer decision replaces an unaccepted one; losing it is flagged, not queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_STRAIGHT;
         cmd_valid <= 1'b0;
         cmd_turn  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            cmd_valid <= 1'b1;
            cmd_turn  <= (state_nxt == ST_TURNING);
            if (cmd_valid && !cmd_ready) overrun <= 1'b1;
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_snn_pred_filter.sv
// Directed bench for snn_pred_filter; command payloads are checked by a scoreboard monitor.
module tb_snn_pred_filter;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst, inf_done, inf_class, clear, cmd_ready;
   logic             cmd_valid, cmd_turn, turning, overrun;
   logic [CNT_W-1:0] fill_count, turn_count;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   snn_pred_filter #(.WINDOW(8), .ON_THRESH(6), .OFF_THRESH(2)) dut (
      .clk(clk), .rst(rst), .inf_done(inf_done), .inf_class(inf_class), .clear(clear),
      .cmd_valid(cmd_valid), .cmd_turn(cmd_turn), .cmd_ready(cmd_ready),
      .turning(turning), .fill_count(fill_count), .turn_count(turn_count), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Monitor: every accepted command must match the oldest expected payload.
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected actual=%0d required=none", cmd_turn);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(cmd_turn) != e) begin
               errors++;
               $display("FAIL cmd_payload actual=%0d required=%0d", cmd_turn, e);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One done pulse; returns once the FSM result is visible.
   task automatic send(input logic c);
      inf_done  = 1'b1;
      inf_class = c;
      tick();
      inf_done = 1'b0;
      tick();
   endtask

   task automatic handshake();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("cmd_valid_after_hs", cmd_valid, 0);
   endtask

   // Counts still in the inclusive 2..5 band must never produce a command from STRAIGHT.
   localparam logic [8:0] BAND_PAT = 9'b1_0001_1111; // bit i = sample i
   int band_exp[9] = '{2, 2, 3, 4, 5, 5, 5, 5, 5};

   initial begin
      logic [8:0] pat;
      pat = BAND_PAT;
      rst = 1'b1; inf_done = 1'b0; inf_class = 1'b0; clear = 1'b0; cmd_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_turning", turning, 0);
      check("rst_fill", fill_count, 0);
      check("rst_overrun", overrun, 0);

      // Fill: no decision until the window is full, then 2-cycle latency.
      for (int i = 0; i < 7; i++) send(1'b1);
      check("fill7_fill", fill_count, 7);
      check("fill7_turn", turn_count, 7);
      check("fill7_cmd_valid", cmd_valid, 0);
      inf_done = 1'b1; inf_class = 1'b1;
      tick();
      inf_done = 1'b0;
      check("fill8_fill", fill_count, 8);
      check("fill8_turn", turn_count, 8);
      check("fill8_lat1_valid", cmd_valid, 0);
      tick();
      check("fill8_lat2_valid", cmd_valid, 1);
      check("fill8_cmd_turn", cmd_turn, 1);
      check("fill8_turning", turning, 1);
      exp_q.push_back(1);
      handshake();

      // Hysteresis down from TURNING.
      for (int i = 0; i < 5; i++) begin
         send(1'b0);
         check("hyst_turn", turn_count, 7 - i);
         check("hyst_no_cmd", cmd_valid, 0);
      end
      send(1'b0);
      check("hyst_off_turn", turn_count, 2);
      check("hyst_off_valid", cmd_valid, 1);
      check("hyst_off_cmd_turn", cmd_turn, 0);
      check("hyst_off_turning", turning, 0);
      exp_q.push_back(0);
      handshake();
      for (int i = 0; i < 9; i++) begin
         send(pat[i]);
         check("band_turn", turn_count, band_exp[i]);
         check("band_no_cmd", cmd_valid, 0);
      end

      // Level done counts once per rising edge.
      clear = 1'b1; tick(); clear = 1'b0;
      check("clr_fill", fill_count, 0);
      inf_done = 1'b1; inf_class = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("level_fill", fill_count, 1);
      inf_done = 1'b0; tick();
      inf_done = 1'b1; tick();
      inf_done = 1'b0; tick();
      check("level_fill2", fill_count, 2);
      check("level_turn2", turn_count, 2);

      // Same-cycle accept and reload keeps valid high without overrun.
      for (int i = 0; i < 6; i++) send(1'b1);
      check("sc_turning", turning, 1);
      check("sc_valid", cmd_valid, 1);
      exp_q.push_back(1);
      for (int i = 0; i < 5; i++) send(1'b0);
      inf_done = 1'b1; inf_class = 1'b0;
      tick();
      inf_done = 1'b0; cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("sc_valid_kept", cmd_valid, 1);
      check("sc_payload", cmd_turn, 0);
      check("sc_overrun", overrun, 0);
      exp_q.push_back(0);
      handshake();

      // Backpressure: two transitions while stalled, latest payload wins.
      for (int i = 0; i < 6; i++) send(1'b1);
      check("bp_first_valid", cmd_valid, 1);
      for (int i = 0; i < 6; i++) send(1'b0);
      check("bp_turning", turning, 0);
      check("bp_payload", cmd_turn, 0);
      check("bp_overrun", overrun, 1);
      exp_q.push_back(0);
      handshake();
      check("bp_overrun_sticky", overrun, 1);

      // Clear coinciding with a done edge drops the sample.
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b1);
      check("clr5_fill", fill_count, 5);
      inf_done = 1'b1; inf_class = 1'b1; clear = 1'b1;
      tick();
      inf_done = 1'b0; clear = 1'b0;
      tick(); tick();
      check("clr_drop_fill", fill_count, 0);
      check("clr_drop_turn", turn_count, 0);
      check("clr_keep_turning", turning, 0);
      check("clr_keep_overrun", overrun, 1);

      // Reset with a command pending; done held high across reset is accepted.
      for (int i = 0; i < 8; i++) send(1'b1);
      check("pre_rst_valid", cmd_valid, 1);
      rst = 1'b1; inf_done = 1'b1; inf_class = 1'b1;
      tick();
      check("rst2_valid", cmd_valid, 0);
      check("rst2_turn", cmd_turn, 0);
      check("rst2_turning", turning, 0);
      check("rst2_fill", fill_count, 0);
      check("rst2_overrun", overrun, 0);
      rst = 1'b0;
      tick();
      inf_done = 1'b0;
      check("post_rst_fill", fill_count, 1);
      check("post_rst_turn", turn_count, 1);
      tick(); tick();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
